// File: rtl/bg_tile_renderer.sv
// rtl/bg_tile_renderer.sv - pipelined background tile renderer with double-buffered row map and row scroll
module bg_tile_renderer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int TILE_LOG2  = 5,
  parameter int NUM_ROWS   = 15,
  parameter int COLOR_BITS = 3,
  parameter int BRAM_LAT   = 1,
  parameter int FRAME_DIV  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [9:0]            h_count_i,
  input  logic [8:0]            v_count_i,
  input  logic                  map_we_i,
  input  logic [3:0]            map_addr_i,
  input  logic [3:0]            map_data_i,
  input  logic [5:0]            pixel_data_i,
  output logic [TILE_LOG2-1:0]  sprite_x_o,
  output logic [TILE_LOG2-1:0]  sprite_y_o,
  output logic [1:0]            sprite_sel_o,
  output logic [COLOR_BITS-1:0] bg_r_o,
  output logic [COLOR_BITS-1:0] bg_g_o,
  output logic [COLOR_BITS-1:0] bg_b_o,
  output logic                  bg_valid_o
);
  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int DL_W = BRAM_LAT + 1;

  typedef logic [3:0] row_entry_t;

  row_entry_t shadow_q [NUM_ROWS];
  row_entry_t shadow_d [NUM_ROWS];
  row_entry_t active_q [NUM_ROWS];
  row_entry_t active_d [NUM_ROWS];

  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [TILE_LOG2-1:0] off_q, off_d;
  logic                 origin_q, origin_d, frame_start;

  logic                 act_s0, vis_s0;
  logic [8:0]           row_s0;
  row_entry_t           ent_s0;
  logic [TILE_LOG2-1:0] off_s0, sx_s0;

  logic [DL_W-1:0]       vis_q, act_q;
  logic [COLOR_BITS-1:0] r_d, g_d, b_d;

  function automatic row_entry_t default_row(input int r);
    case (r)
      0:                       return 4'b0001;
      2, 3, 4, 7, 8, 11, 12, 13: return {r[0], 1'b1, 2'b10};
      5, 9, 14:                return 4'b0011;
      default:                 return 4'b0000;
    endcase
  endfunction

  // Writes land in the shadow first so a write on the frame-start clock is part of that copy.
  always_comb begin
    origin_d    = (h_count_i == '0) && (v_count_i == '0);
    frame_start = origin_d && !origin_q;
    shadow_d    = shadow_q;
    if (map_we_i && (32'(map_addr_i) < NUM_ROWS)) shadow_d[map_addr_i] = map_data_i;
    active_d    = active_q;
    frame_cnt_d = frame_cnt_q;
    off_d       = off_q;
    if (frame_start) begin
      active_d = shadow_d;
      if (32'(frame_cnt_q) == FRAME_DIV - 1) begin
        frame_cnt_d = '0;
        off_d       = off_q + TILE_LOG2'(1);
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // The frame-start pixel already uses the freshly copied map and scroll offset.
  always_comb begin
    act_s0 = (32'(h_count_i) < H_ACTIVE) && (32'(v_count_i) < V_ACTIVE);
    row_s0 = v_count_i >> TILE_LOG2;
    ent_s0 = '0;
    if (act_s0 && (32'(row_s0) < NUM_ROWS)) ent_s0 = active_d[row_s0[3:0]];
    off_s0 = ent_s0[2] ? off_d : '0;
    sx_s0  = ent_s0[3] ? (h_count_i[TILE_LOG2-1:0] - off_s0)
                       : (h_count_i[TILE_LOG2-1:0] + off_s0);
    vis_s0 = (ent_s0[1:0] != 2'b00);
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vis_q[BRAM_LAT] && (pixel_data_i != '0)) begin
      r_d = COLOR_BITS'(pixel_data_i[5:4]) << (COLOR_BITS - 2);
      g_d = COLOR_BITS'(pixel_data_i[3:2]) << (COLOR_BITS - 2);
      b_d = COLOR_BITS'(pixel_data_i[1:0]) << (COLOR_BITS - 2);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        shadow_q[i] <= default_row(i);
        active_q[i] <= default_row(i);
      end
      frame_cnt_q  <= '0;
      off_q        <= '0;
      origin_q     <= 1'b0;
      sprite_x_o   <= '0;
      sprite_y_o   <= '0;
      sprite_sel_o <= '0;
      vis_q        <= '0;
      act_q        <= '0;
      bg_r_o       <= '0;
      bg_g_o       <= '0;
      bg_b_o       <= '0;
      bg_valid_o   <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      frame_cnt_q  <= frame_cnt_d;
      off_q        <= off_d;
      origin_q     <= origin_d;
      sprite_x_o   <= sx_s0;
      sprite_y_o   <= v_count_i[TILE_LOG2-1:0];
      sprite_sel_o <= ent_s0[1:0];
      vis_q        <= (vis_q << 1) | DL_W'(vis_s0);
      act_q        <= (act_q << 1) | DL_W'(act_s0);
      bg_r_o       <= r_d;
      bg_g_o       <= g_d;
      bg_b_o       <= b_d;
      bg_valid_o   <= act_q[BRAM_LAT];
    end
  end
endmodule

// File: tb/tb_bg_tile_renderer.sv
// tb/tb_bg_tile_renderer.sv - randomized self-checking bench for bg_tile_renderer
`timescale 1ns/1ps
module tb_bg_tile_renderer;
  localparam int BL   = 1;
  localparam int FDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h;
  logic [8:0] v;
  logic       we;
  logic [3:0] addr, data;
  logic [5:0] pix;
  logic [4:0] sx, sy;
  logic [1:0] sel;
  logic [2:0] r, g, b;
  logic       vld;

  always #5 clk = ~clk;

  bg_tile_renderer #(
    .H_ACTIVE(640), .V_ACTIVE(480), .TILE_LOG2(5), .NUM_ROWS(15),
    .COLOR_BITS(3), .BRAM_LAT(BL), .FRAME_DIV(FDIV)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .h_count_i(h), .v_count_i(v),
    .map_we_i(we), .map_addr_i(addr), .map_data_i(data), .pixel_data_i(pix),
    .sprite_x_o(sx), .sprite_y_o(sy), .sprite_sel_o(sel),
    .bg_r_o(r), .bg_g_o(g), .bg_b_o(b), .bg_valid_o(vld)
  );

  typedef struct {
    logic [4:0] sx;
    logic [4:0] sy;
    logic [1:0] sel;
    logic       vld;
    logic [2:0] r, g, b;
    logic [5:0] pix;
  } px_t;

  px_t        pq[$];
  logic [3:0] shadow_m [15];
  logic [3:0] active_m [15];
  int         nfs;
  bit         prev_origin;
  int         nchk = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dflt(input int row);
    if (row == 0) return 4'b0001;
    if (row inside {2, 3, 4, 7, 8, 11, 12, 13}) return (row % 2 == 1) ? 4'b1110 : 4'b0110;
    if (row inside {5, 9, 14}) return 4'b0011;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    nfs = 0;
    prev_origin = 1'b0;
    for (int i = 0; i < 15; i++) begin
      shadow_m[i] = dflt(i);
      active_m[i] = dflt(i);
    end
    pq.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sx"}, 32'(sx), 0);
    chk({tag, "_sy"}, 32'(sy), 0);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_r"}, 32'(r), 0);
    chk({tag, "_g"}, 32'(g), 0);
    chk({tag, "_b"}, 32'(b), 0);
    chk({tag, "_valid"}, 32'(vld), 0);
  endtask

  // One pixel per call: check what is due, act as the BRAM, drive the next pixel, advance one clock.
  task automatic step(input int hh, input int vv, input bit w, input int a, input int d, input int p);
    px_t        e;
    int         row, offv;
    logic [3:0] ent;
    bit         act, origin;
    if (pq.size() == 0) begin
      chk("sprite_x_refill", 32'(sx), 0);
      chk("sprite_sel_refill", 32'(sel), 0);
    end else begin
      chk("sprite_x", 32'(sx), 32'(pq[$].sx));
      chk("sprite_y", 32'(sy), 32'(pq[$].sy));
      chk("sprite_sel", 32'(sel), 32'(pq[$].sel));
    end
    if (pq.size() == BL + 2) begin
      chk("bg_r", 32'(r), 32'(pq[0].r));
      chk("bg_g", 32'(g), 32'(pq[0].g));
      chk("bg_b", 32'(b), 32'(pq[0].b));
      chk("bg_valid", 32'(vld), 32'(pq[0].vld));
      void'(pq.pop_front());
    end else begin
      chk("bg_valid_refill", 32'(vld), 0);
      chk("bg_r_refill", 32'(r), 0);
    end
    pix  = (pq.size() == BL + 1) ? pq[0].pix : 6'd0;
    h    = 10'(hh);
    v    = 9'(vv);
    we   = w;
    addr = 4'(a);
    data = 4'(d);
    origin = (hh == 0) && (vv == 0);
    if (origin && !prev_origin) begin
      if (w && a < 15) shadow_m[a] = 4'(d);
      active_m = shadow_m;
      nfs++;
    end else if (w && a < 15) begin
      shadow_m[a] = 4'(d);
    end
    prev_origin = origin;
    act = (hh < 640) && (vv < 480);
    row = vv / 32;
    ent = 4'b0000;
    if (act && row < 15) ent = active_m[row];
    offv  = ent[2] ? (nfs / FDIV) % 32 : 0;
    e.sx  = ent[3] ? 5'((hh + 32 - offv) % 32) : 5'((hh + offv) % 32);
    e.sy  = 5'(vv % 32);
    e.sel = ent[1:0];
    e.vld = act;
    e.pix = 6'(p);
    if (ent[1:0] != 2'b00 && p != 0) begin
      e.r = 3'((p / 16) * 2);
      e.g = 3'(((p / 4) % 4) * 2);
      e.b = 3'((p % 4) * 2);
    end else begin
      e.r = 3'd0;
      e.g = 3'd0;
      e.b = 3'd0;
    end
    pq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int rnd_pix();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
  endfunction

  task automatic rstep(input int hh, input int vv);
    step(hh, vv, 1'b0, 0, 0, rnd_pix());
  endtask

  task automatic rand_step(input bit allow_write, input int row);
    int hh, vv;
    hh = int'($urandom_range(0, 799));
    vv = (row < 0) ? int'($urandom_range(0, 511)) : row * 32 + int'($urandom_range(0, 31));
    if (hh == 0 && vv == 0) hh = 1;
    if (allow_write && $urandom_range(0, 3) == 0)
      step(hh, vv, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), rnd_pix());
    else
      rstep(hh, vv);
  endtask

  initial begin
    rst_n = 1'b0;
    h = '0; v = '0; we = 1'b0; addr = '0; data = '0; pix = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    rstep(0, 0);
    for (int row = 0; row < 16; row++)
      for (int k = 0; k < 8; k++) rand_step(1'b0, row);

    step(5, 70, 1'b0, 0, 0, 6'b110110);
    chk("row2_sel", 32'(sel), 2);
    chk("row2_sy", 32'(sy), 6);
    rstep(100, 100);
    rstep(101, 100);
    chk("row2_bg_r", 32'(r), 32'(3'b110));
    chk("row2_bg_g", 32'(g), 32'(3'b010));
    chk("row2_bg_b", 32'(b), 32'(3'b100));
    chk("row2_bg_valid", 32'(vld), 1);

    rstep(0, 0);
    rstep(0, 0);
    rstep(0, 0);
    rstep(31, 70);
    chk("held_origin_once", 32'(sx), 31);
    rstep(0, 0);
    rstep(7, 7);
    rstep(0, 0);
    rstep(31, 70);
    chk("scroll_row2", 32'(sx), 0);
    rstep(0, 99);
    chk("scroll_row3", 32'(sx), 31);
    rstep(10, 165);
    chk("row5_no_scroll", 32'(sx), 10);
    chk("row5_sidewalk", 32'(sel), 3);

    step(20, 200, 1'b1, 5, 4'b0001, rnd_pix());
    rstep(10, 165);
    chk("row5_no_tear", 32'(sel), 3);
    rstep(0, 0);
    rstep(10, 165);
    chk("row5_new_frame", 32'(sel), 1);

    step(0, 0, 1'b1, 9, 4'b0010, rnd_pix());
    rstep(5, 293);
    chk("write_at_frame_start", 32'(sel), 2);
    step(40, 40, 1'b1, 15, 4'b0001, rnd_pix());
    rstep(0, 0);
    rstep(5, 40);
    chk("addr15_ignored_row1", 32'(sel), 0);
    for (int row = 0; row < 16; row++)
      for (int k = 0; k < 4; k++) rand_step(1'b0, row);

    for (int i = 0; i < 160; i++) begin
      if (i % 16 == 0) rstep(0, 0);
      else rand_step(1'b1, -1);
    end

    h = 10'd200; v = 9'd100;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midline_reset");
    model_reset();
    pix = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rstep(50, 100);
    rstep(51, 100);
    chk("refill_valid_low", 32'(vld), 0);
    rstep(52, 100);
    chk("refill_valid_back", 32'(vld), 1);

    for (int i = 0; i < 80; i++) begin
      if (i % 20 == 0) rstep(0, 0);
      else rand_step(1'b1, -1);
    end
    for (int i = 0; i < BL + 2; i++) rstep(600, 300);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
